// File: rtl/data_memory_access_unit.sv
// Data-memory initiator: turns MEM-stage load/store requests into memory bus cycles.
// Optional out-of-range fault path is enabled by defining DATA_MEM_RANGE_CHECK_EN.
module data_memory_access_unit #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int MEM_DEPTH    = 256
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_write_en,
    output logic                  mem_read_en
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Read enable is held for READ_LATENCY+1 cycles; the counter value on the last one.
    localparam logic [2:0] READ_LAST = 3'(READ_LATENCY);

    if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
        $error("READ_LATENCY must be in 1..7");
    end
    if (MEM_DEPTH < 1) begin : g_bad_depth
        $error("MEM_DEPTH must be positive");
    end

    logic [1:0] state;
    logic [2:0] count;
    logic       accept;
    logic       resp_taken;
    logic       out_of_range;

    assign req_ready  = (state == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_taken = (state == ST_RESP) && resp_ready;

`ifdef DATA_MEM_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic fault_q;

    assign out_of_range = ({1'b0, req_addr} >= DEPTH_LIMIT);
    assign resp_fault   = fault_q;

    // Fault flag is decided at accept and held through the response handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else if (accept) begin
            fault_q <= out_of_range;
        end else if (resp_taken) begin
            fault_q <= 1'b0;
        end
    end
`else
    assign out_of_range = 1'b0;
    assign resp_fault   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            count        <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            resp_rdata   <= '0;
            mem_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
            resp_valid   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        mem_addr <= req_addr;
                        if (req_write) begin
                            mem_wdata <= req_wdata;
                        end
                        if (out_of_range) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_write) begin
                            state        <= ST_WRITE;
                            mem_write_en <= 1'b1;
                        end else begin
                            state       <= ST_READ;
                            mem_read_en <= 1'b1;
                            count       <= '0;
                        end
                    end
                end
                ST_READ: begin
                    if (count == READ_LAST) begin
                        // Memory output bus is valid on the final read-enable cycle.
                        resp_rdata  <= mem_rdata;
                        mem_read_en <= 1'b0;
                        resp_valid  <= 1'b1;
                        count       <= '0;
                        state       <= ST_RESP;
                    end else begin
                        count <= count + 3'd1;
                    end
                end
                ST_WRITE: begin
                    mem_write_en <= 1'b0;
                    resp_valid   <= 1'b1;
                    state        <= ST_RESP;
                end
                default: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
